// File: rtl/i2c_wb_cmd_seq_if.sv
// i2c_wb_cmd_seq_if: request/response handshake plus WISHBONE master bus
// between the command sequencer and its neighbours.
//
// Signals
//   req_valid/req_ready     request handshake (accepted when both high)
//   req_rw/dev/reg/wdata    request payload (0=write, 1=read)
//   resp_valid/err/rdata    one-cycle completion report
//   wbm_*                   WISHBONE master toward the I2C controller
//
// Modports
//   master  the sequencer's view
//   slave   the environment's view (requester + controller)
interface i2c_wb_cmd_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic [1:0] resp_err;
    logic [7:0] resp_rdata;
    logic [2:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i;
    logic       wbm_we_o;
    logic       wbm_stb_o;
    logic       wbm_cyc_o;
    logic       wbm_ack_i;

    modport master (
        input  req_valid, req_rw, req_dev, req_reg, req_wdata,
        input  wbm_dat_i, wbm_ack_i,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
    );

    modport slave (
        output req_valid, req_rw, req_dev, req_reg, req_wdata,
        output wbm_dat_i, wbm_ack_i,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
    );
endinterface

// File: rtl/i2c_wb_cmd_seq.sv
// i2c_wb_cmd_seq: WISHBONE master that initialises the I2C controller and
// turns one register read/write request into the full START..STOP sequence.
//
// Ports
//   wb_clk_i  clock (rising edge)
//   arst_i    asynchronous active-high reset; aborts without a STOP
//   irq_i     controller interrupt, only with I2C_SEQ_IRQ_EN defined
//   bus       i2c_wb_cmd_seq_if.master (request/response + WB master)
//
// Parameters
//   PRESCALE  value written to PRERlo/PRERhi during init
//   POLL_MAX  max SR reads (or irq wait cycles) per wait before timeout
//
// Configuration macro
//   I2C_SEQ_IRQ_EN  wait for irq_i, read SR once, then IACK
//                   (undefined: poll SR until TIP clears)
//
// resp_err: 0 ok, 1 NACK, 2 arbitration lost, 3 timeout.
module i2c_wb_cmd_seq #(
    parameter logic [15:0] PRESCALE = 16'd99,
    parameter logic [15:0] POLL_MAX = 16'd1023
) (
    input logic              wb_clk_i,
    input logic              arst_i,
`ifdef I2C_SEQ_IRQ_EN
    input logic              irq_i,
`endif
    i2c_wb_cmd_seq_if.master bus
);

    localparam logic [2:0] A_PRERLO = 3'd0;
    localparam logic [2:0] A_PRERHI = 3'd1;
    localparam logic [2:0] A_CTR    = 3'd2;
    localparam logic [2:0] A_TXR    = 3'd3;
    localparam logic [2:0] A_CR     = 3'd4;

`ifdef I2C_SEQ_IRQ_EN
    localparam logic [7:0] CTR_INIT = 8'hC0;
`else
    localparam logic [7:0] CTR_INIT = 8'h80;
`endif

    typedef enum logic [3:0] {
        S_INIT0, S_INIT1, S_INIT2, S_IDLE,
        S_TXR,   S_CR,    S_IRQW,  S_POLL,
        S_IACK,  S_ADV,   S_STOP,  S_BUSY,
        S_RXR,   S_DONE
    } state_t;

    state_t      state_q, state_d;

    logic        stb_q;
    logic        we_q;
    logic [2:0]  adr_q;
    logic [7:0]  dat_q;

    logic        rw_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;
    logic [1:0]  phase_q, phase_d;
    logic [1:0]  err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  rdata_q;

    logic        go;
    logic        go_we;
    logic [2:0]  go_adr;
    logic [7:0]  go_dat;
    logic        latch;
    logic        rdata_ld;

    logic        acked;
    logic [15:0] cnt_inc;
    logic        tmo;
    logic        chk_rx;
    logic [7:0]  tx_dat;
    logic [7:0]  cr_dat;

    assign acked   = stb_q & bus.wbm_ack_i;
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign tmo     = cnt_inc > POLL_MAX;
    // Phase 3 is the final NACKed read byte: RxACK is not meaningful there.
    assign chk_rx  = phase_q != 2'd3;

    // Phases: 0 dev addr, 1 reg index, 2 write data / re-addr, 3 read byte.
    always_comb begin
        tx_dat = 8'h00;
        cr_dat = 8'h00;
        case (phase_q)
            2'd0: begin
                tx_dat = {dev_q, 1'b0};
                cr_dat = 8'h90;
            end
            2'd1: begin
                tx_dat = reg_q;
                cr_dat = 8'h10;
            end
            2'd2: begin
                tx_dat = rw_q ? {dev_q, 1'b1} : wdata_q;
                cr_dat = rw_q ? 8'h90 : 8'h50;
            end
            default: cr_dat = 8'h68;
        endcase
    end

    // A bus state issues its access while stb is low and advances on ack;
    // stb drops on the ack edge, so accesses are always separated.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        go       = 1'b0;
        go_we    = 1'b0;
        go_adr   = 3'd0;
        go_dat   = 8'h00;
        latch    = 1'b0;
        rdata_ld = 1'b0;
        case (state_q)
            S_INIT0: begin
                go     = !stb_q;
                go_we  = 1'b1;
                go_adr = A_PRERLO;
                go_dat = PRESCALE[7:0];
                if (acked) state_d = S_INIT1;
            end
            S_INIT1: begin
                go     = !stb_q;
                go_we  = 1'b1;
                go_adr = A_PRERHI;
                go_dat = PRESCALE[15:8];
                if (acked) state_d = S_INIT2;
            end
            S_INIT2: begin
                go     = !stb_q;
                go_we  = 1'b1;
                go_adr = A_CTR;
                go_dat = CTR_INIT;
                if (acked) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.req_valid) begin
                    latch   = 1'b1;
                    phase_d = 2'd0;
                    err_d   = 2'd0;
                    state_d = S_TXR;
                end
            end
            S_TXR: begin
                go     = !stb_q;
                go_we  = 1'b1;
                go_adr = A_TXR;
                go_dat = tx_dat;
                if (acked) state_d = S_CR;
            end
            S_CR: begin
                go     = !stb_q;
                go_we  = 1'b1;
                go_adr = A_CR;
                go_dat = cr_dat;
                if (acked) begin
                    cnt_d = 16'd0;
`ifdef I2C_SEQ_IRQ_EN
                    state_d = S_IRQW;
`else
                    state_d = S_POLL;
`endif
                end
            end
`ifdef I2C_SEQ_IRQ_EN
            S_IRQW: begin
                if (irq_i) begin
                    state_d = S_POLL;
                end else begin
                    cnt_d = cnt_inc;
                    if (tmo) begin
                        err_d   = 2'd3;
                        state_d = S_STOP;
                    end
                end
            end
            S_POLL: begin
                go     = !stb_q;
                go_adr = A_CR;
                if (acked) begin
                    if (bus.wbm_dat_i[5])
                        err_d = 2'd2;
                    else if (bus.wbm_dat_i[7] && chk_rx)
                        err_d = 2'd1;
                    state_d = S_IACK;
                end
            end
            S_IACK: begin
                go     = !stb_q;
                go_we  = 1'b1;
                go_adr = A_CR;
                go_dat = 8'h01;
                if (acked) begin
                    case (err_q)
                        2'd2:    state_d = S_DONE;
                        2'd1:    state_d = S_STOP;
                        default: state_d = S_ADV;
                    endcase
                end
            end
`else
            S_POLL: begin
                go     = !stb_q;
                go_adr = A_CR;
                if (acked) begin
                    if (bus.wbm_dat_i[5]) begin
                        err_d   = 2'd2;
                        state_d = S_DONE;
                    end else if (bus.wbm_dat_i[1]) begin
                        cnt_d = cnt_inc;
                        if (tmo) begin
                            err_d   = 2'd3;
                            state_d = S_STOP;
                        end
                    end else if (bus.wbm_dat_i[7] && chk_rx) begin
                        err_d   = 2'd1;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_ADV;
                    end
                end
            end
`endif
            S_ADV: begin
                if (phase_q == 2'd3) begin
                    state_d = S_RXR;
                end else if (phase_q == 2'd2 && !rw_q) begin
                    state_d = S_DONE;
                end else begin
                    phase_d = phase_q + 2'd1;
                    // The read byte has no TXR load, only the command.
                    state_d = (phase_q == 2'd2) ? S_CR : S_TXR;
                end
            end
            S_STOP: begin
                go     = !stb_q;
                go_we  = 1'b1;
                go_adr = A_CR;
                go_dat = 8'h40;
                if (acked) begin
                    cnt_d   = 16'd0;
                    state_d = (err_q == 2'd1) ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                // Bounded by the same limit so a stuck bus cannot hang us;
                // the NACK code is reported either way.
                go     = !stb_q;
                go_adr = A_CR;
                if (acked) begin
                    if (!bus.wbm_dat_i[6]) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (tmo) state_d = S_DONE;
                    end
                end
            end
            S_RXR: begin
                go     = !stb_q;
                go_adr = A_TXR;
                if (acked) begin
                    rdata_ld = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_INIT0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_INIT0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 3'd0;
            dat_q   <= 8'h00;
            rw_q    <= 1'b0;
            dev_q   <= 7'd0;
            reg_q   <= 8'h00;
            wdata_q <= 8'h00;
            phase_q <= 2'd0;
            err_q   <= 2'd0;
            cnt_q   <= 16'd0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (go) begin
                stb_q <= 1'b1;
                we_q  <= go_we;
                adr_q <= go_adr;
                dat_q <= go_dat;
            end else if (acked) begin
                stb_q <= 1'b0;
                we_q  <= 1'b0;
            end
            if (latch) begin
                rw_q    <= bus.req_rw;
                dev_q   <= bus.req_dev;
                reg_q   <= bus.req_reg;
                wdata_q <= bus.req_wdata;
            end
            if (rdata_ld) rdata_q <= bus.wbm_dat_i;
        end
    end

    assign bus.req_ready  = state_q == S_IDLE;
    assign bus.resp_valid = state_q == S_DONE;
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.wbm_adr_o  = adr_q;
    assign bus.wbm_dat_o  = dat_q;
    assign bus.wbm_we_o   = we_q;
    assign bus.wbm_stb_o  = stb_q;
    assign bus.wbm_cyc_o  = stb_q;

endmodule
